reg_a_write_arbiter: RTL and testbench
======================================

Name: reg_a_write_arbiter

Overview:
Round-robin arbiter that shares the write port of the 4-bit A register between three requesters (e.g. ALU result path, immediate-load path, debug/test loader). It registers a one-hot grant, forms the register's write-enable and write-data from the granted requester, and bounds ownership with a hold limit. It sits directly in front of the A register. Its we/wdata outputs drive that register's load enable and DATA input.

Parameters:
WIDTH, 4, data width of the A register and of each requester's data bus
MAX_HOLD, 4, maximum consecutive granted cycles before a forced hand-over when others are waiting (legal range 1..15)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
req  input  3  request per requester, bit i = requester i
data0  input  WIDTH  write data from requester 0
data1  input  WIDTH  write data from requester 1
data2  input  WIDTH  write data from requester 2
gnt  output  3  registered one-hot grant, 000 = no owner
we  output  1  write enable to A register = |(gnt & req), combinational
wdata  output  WIDTH  data of granted requester (mux on gnt), 0 when gnt = 000
busy  output  1  registered, 1 whenever gnt != 000

Behaviour:
- Reset (reset = 0, async): gnt=000, busy=0, state=IDLE, ptr=0, hold_cnt=0. Hence we=0 and wdata=0 immediately, without waiting for a clock edge. Reset dominates every other event, including reset asserted mid-grant.
- State: IDLE / GRANT. ptr (0..2) is the round-robin start index. hold_cnt (4 bits) counts cycles the current owner has held the grant.
- Search order from index k: k, k+1, k+2 (mod 3). The first requester with req high wins.
- IDLE, rising edge with req != 000: grant the winner of search from ptr, go to GRANT, hold_cnt=1. With req == 000: stay IDLE.
- GRANT, owner's req low at edge (voluntary release): ptr = owner+1 mod 3. If any other req is high, grant the winner of search from the new ptr in the same edge, with no idle cycle, and hold_cnt=1. Otherwise gnt=000, go to IDLE, hold_cnt=0.
- GRANT, owner's req high and hold_cnt == MAX_HOLD and another req high (forced release): same as voluntary release; the owner loses the grant at this edge.
- GRANT, owner's req high otherwise: keep grant. hold_cnt increments and saturates at MAX_HOLD. A lone requester therefore holds indefinitely.
- Grant latency: a request sampled high at edge t in IDLE yields gnt visible after edge t (one cycle).
- we falls combinationally in the same cycle the owner drops req, so no spurious write occurs. The A register writes on every cycle where we=1.
- gnt is always one-hot or zero; no two bits are ever set.
- Requests arriving simultaneously are resolved only by ptr order. No requester is ever starved: each waits at most 2*MAX_HOLD cycles plus 2.
- Data inputs are not registered. Requesters must hold data stable while req is high.

Test Plan:
1. Hold reset=0 with req=111 → gnt=000, we=0, wdata=0. Release reset with req=001, data0=4'hA → after next edge gnt=001, we=1, wdata=4'hA, busy=1.
2. MAX_HOLD=4, req=101 held constant → gnt=001 for 4 cycles, then 100 for 4 cycles, then 001 again. Switches occur with no gnt=000 cycle, and we=1 throughout.
3. Requester 0 owns, req=011, then req0 drops after 2 granted cycles → we=0 in that same cycle; at the next edge gnt=010 and wdata=data1.
4. Only req=010 held for 10 cycles → gnt=010 for all 10 cycles with no forced release, and hold_cnt saturates at 4.
5. Drive reset=0 between clock edges while gnt=100 → gnt=000, we=0, busy=0 immediately. After release with req=111, the first grant is 001 (ptr reset to 0).
6. Owner 1 drops req with req=000 → gnt=000, state IDLE after the edge. A following req=101 grants 100, because ptr=2 after the release from requester 1.

Source files
------------

// File: rtl/reg_a_write_arbiter.sv
// Round-robin write-port arbiter for the 4-bit A register: three requesters,
// registered one-hot grant, bounded ownership via a hold limit.
module reg_a_write_arbiter #(
  parameter int WIDTH    = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       req,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  output logic [2:0]       gnt,
  output logic             we,
  output logic [WIDTH-1:0] wdata,
  output logic             busy
);

  localparam logic       S_IDLE   = 1'b0;
  localparam logic       S_GRANT  = 1'b1;
  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

  logic       state, state_nxt;
  logic [1:0] ptr, ptr_nxt;
  logic [3:0] hold_cnt, hold_nxt;
  logic [2:0] gnt_nxt;
  logic [1:0] owner, owner_inc;
  logic [2:0] others;
  logic       owner_req, hand_over;

  // First set bit of r searching k, k+1, k+2 (mod 3); zero if r is zero.
  function automatic logic [2:0] pick(input logic [2:0] r, input logic [1:0] k);
    logic [2:0] rot, p, sel;
    case (k)
      2'd1:    rot = {r[0], r[2], r[1]};
      2'd2:    rot = {r[1], r[0], r[2]};
      default: rot = r;
    endcase
    p = rot[0] ? 3'b001 : rot[1] ? 3'b010 : rot[2] ? 3'b100 : 3'b000;
    case (k)
      2'd1:    sel = {p[1], p[0], p[2]};
      2'd2:    sel = {p[0], p[2], p[1]};
      default: sel = p;
    endcase
    return sel;
  endfunction

  assign owner     = gnt[1] ? 2'd1 : gnt[2] ? 2'd2 : 2'd0;
  assign owner_inc = (owner == 2'd2) ? 2'd0 : owner + 2'd1;
  assign owner_req = |(gnt & req);
  assign others    = req & ~gnt;
  assign hand_over = !owner_req || (hold_cnt == HOLD_MAX && |others);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    hold_nxt  = hold_cnt;
    gnt_nxt   = gnt;
    if (state == S_IDLE) begin
      if (|req) begin
        gnt_nxt   = pick(req, ptr);
        state_nxt = S_GRANT;
        hold_nxt  = 4'd1;
      end
    end else if (hand_over) begin
      // Hand over in the same edge so the port never idles while others wait.
      ptr_nxt = owner_inc;
      gnt_nxt = pick(others, owner_inc);
      if (|others) begin
        hold_nxt = 4'd1;
      end else begin
        state_nxt = S_IDLE;
        hold_nxt  = 4'd0;
      end
    end else if (hold_cnt != HOLD_MAX) begin
      hold_nxt = hold_cnt + 4'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      ptr      <= 2'd0;
      hold_cnt <= 4'd0;
      gnt      <= 3'b000;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_nxt;
      gnt      <= gnt_nxt;
      busy     <= |gnt_nxt;
    end
  end

  // we drops combinationally when the owner releases, so no stray write.
  assign we    = owner_req;
  assign wdata = ({WIDTH{gnt[0]}} & data0) |
                 ({WIDTH{gnt[1]}} & data1) |
                 ({WIDTH{gnt[2]}} & data2);

endmodule

// File: tb/tb_reg_a_write_arbiter.sv
// Directed bench for reg_a_write_arbiter: expected outputs are queued with
// each stimulus step and popped when the DUT output is sampled.
module tb_reg_a_write_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] req = 3'b000;
  logic [3:0] data0 = 4'hA, data1 = 4'h5, data2 = 4'hC;
  logic [2:0] gnt;
  logic       we, busy;
  logic [3:0] wdata;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string      tag;
    logic [2:0] gnt;
    logic       we;
    logic [3:0] wdata;
    logic       busy;
  } exp_t;

  exp_t sb[$];

  reg_a_write_arbiter #(.WIDTH(4), .MAX_HOLD(4)) dut (
    .clk(clk), .reset(reset), .req(req),
    .data0(data0), .data1(data1), .data2(data2),
    .gnt(gnt), .we(we), .wdata(wdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic expect_out(input string tag, input logic [2:0] g, input logic w,
                            input logic [3:0] d, input logic b);
    exp_t e;
    e.tag = tag; e.gnt = g; e.we = w; e.wdata = d; e.busy = b;
    sb.push_back(e);
  endtask

  task automatic cmp(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    n_tests++;
    assert (sb.size() != 0) else begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed 0 entries expected >= 1");
      return;
    end
    e = sb.pop_front();
    cmp({e.tag, ".gnt"},   {1'b0, gnt}, {1'b0, e.gnt});
    cmp({e.tag, ".we"},    {3'b0, we},  {3'b0, e.we});
    cmp({e.tag, ".wdata"}, wdata,       e.wdata);
    cmp({e.tag, ".busy"},  {3'b0, busy},{3'b0, e.busy});
  endtask

  task automatic drive(input logic [2:0] r);
    @(negedge clk);
    req = r;
  endtask

  task automatic edge_check();
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    // 1: reset holds outputs low even with all requests raised.
    #1 reset = 1'b0;
    req = 3'b111;
    #2;
    expect_out("t1_reset", 3'b000, 1'b0, 4'h0, 1'b0);
    check_out();
    @(posedge clk); #1;
    expect_out("t1_reset_edge", 3'b000, 1'b0, 4'h0, 1'b0);
    check_out();
    @(negedge clk);
    reset = 1'b1;
    req   = 3'b001;
    expect_out("t1_first_grant", 3'b001, 1'b1, 4'hA, 1'b1);
    edge_check();

    // 2: req=101 held; 4 cycles each, hand-over with no idle cycle.
    drive(3'b101);
    for (int i = 0; i < 3; i++) begin
      expect_out($sformatf("t2_own0_%0d", i), 3'b001, 1'b1, 4'hA, 1'b1);
      edge_check();
    end
    for (int i = 0; i < 4; i++) begin
      expect_out($sformatf("t2_own2_%0d", i), 3'b100, 1'b1, 4'hC, 1'b1);
      edge_check();
    end
    expect_out("t2_back_to_0", 3'b001, 1'b1, 4'hA, 1'b1);
    edge_check();

    // 3: requester 0 drops after 2 granted cycles; we falls at once.
    drive(3'b011);
    expect_out("t3_hold", 3'b001, 1'b1, 4'hA, 1'b1);
    edge_check();
    drive(3'b010);
    #1;
    expect_out("t3_we_drop", 3'b001, 1'b0, 4'hA, 1'b1);
    check_out();
    expect_out("t3_to_1", 3'b010, 1'b1, 4'h5, 1'b1);
    edge_check();

    // 4: lone requester 1 holds indefinitely; hold count saturates, so a new
    // request is handed the port at the very next edge.
    for (int i = 0; i < 10; i++) begin
      expect_out($sformatf("t4_lone_%0d", i), 3'b010, 1'b1, 4'h5, 1'b1);
      edge_check();
    end
    drive(3'b011);
    expect_out("t4_saturated_forced", 3'b001, 1'b1, 4'hA, 1'b1);
    edge_check();

    // 5: async reset mid-grant; ptr returns to 0.
    drive(3'b100);
    expect_out("t5_own2", 3'b100, 1'b1, 4'hC, 1'b1);
    edge_check();
    #1 reset = 1'b0;
    #1;
    expect_out("t5_async_reset", 3'b000, 1'b0, 4'h0, 1'b0);
    check_out();
    @(negedge clk);
    req   = 3'b111;
    reset = 1'b1;
    expect_out("t5_after_reset", 3'b001, 1'b1, 4'hA, 1'b1);
    edge_check();

    // 6: owner 1 releases into idle; ptr=2 then picks requester 2 first.
    drive(3'b010);
    expect_out("t6_own1", 3'b010, 1'b1, 4'h5, 1'b1);
    edge_check();
    drive(3'b000);
    expect_out("t6_idle", 3'b000, 1'b0, 4'h0, 1'b0);
    edge_check();
    expect_out("t6_idle_stay", 3'b000, 1'b0, 4'h0, 1'b0);
    edge_check();
    drive(3'b101);
    expect_out("t6_ptr2", 3'b100, 1'b1, 4'hC, 1'b1);
    edge_check();

    n_tests++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_leftover: observed %0d expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
